// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// ram_arbiter_pkg : shared state, owner codes and helpers for the SRAM arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   function automatic logic is_req(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_pick2.sv
// ============================================================================
// ram_arbiter_rr_pick2 : combinational two-way round-robin pick
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_arbiter_rr_pick2
   import ram_arbiter_pkg::*;
(
   input  logic   req_cpu_i,
   input  logic   req_dma_i,
   input  owner_t last_grant_i,
   output logic   grant_valid_o,
   output owner_t grant_id_o
);

   always_comb begin
      grant_valid_o = req_cpu_i | req_dma_i;
      grant_id_o    = OWN_CPU;
      // Under contention the master that was not served last wins.
      if (req_cpu_i && req_dma_i) begin
         grant_id_o = (last_grant_i == OWN_CPU) ? OWN_DMA : OWN_CPU;
      end else if (req_dma_i) begin
         grant_id_o = OWN_DMA;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : shares one SRAM port between CPU and DMA masters, round-robin
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int RAM_CYCLES = 2,
   parameter int AW         = 22,
   parameter int DW         = 16
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic [DW-1:0] cpu_rdata_o,
   input  logic          cpu_rd_i,
   input  logic          cpu_wr_i,
   input  logic          cpu_byte_op_i,
   output logic          cpu_ack_o,
   input  logic [AW-1:0] dma_addr_i,
   input  logic [DW-1:0] dma_wdata_i,
   output logic [DW-1:0] dma_rdata_o,
   input  logic          dma_rd_i,
   input  logic          dma_wr_i,
   input  logic          dma_byte_op_i,
   output logic          dma_ack_o,
   output logic [AW-1:0] ram_addr_o,
   output logic [DW-1:0] ram_data_out_o,
   input  logic [DW-1:0] ram_data_in_i,
   output logic          ram_rd_o,
   output logic          ram_wr_o,
   output logic          ram_byte_op_o,
   output logic          dma_owner_o
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_CYCLES - 1);

   state_t           state_q;
   owner_t           last_grant_q;
   owner_t           owner_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [AW-1:0]    addr_q;
   logic [DW-1:0]    wdata_q;
   logic             byte_q;
   logic             wr_q;
   logic             ram_rd_q;
   logic             ram_wr_q;
   logic             cpu_ack_q;
   logic             dma_ack_q;
   logic [DW-1:0]    cpu_rdata_q;
   logic [DW-1:0]    dma_rdata_q;
   logic             dma_owner_q;

   logic             grant_valid;
   owner_t           grant_id;
   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_wdata;
   logic             sel_byte;
   logic             sel_wr;

   ram_arbiter_rr_pick2 u_pick (
      .req_cpu_i     (is_req(cpu_rd_i, cpu_wr_i)),
      .req_dma_i     (is_req(dma_rd_i, dma_wr_i)),
      .last_grant_i  (last_grant_q),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id)
   );

   // Write wins when a master raises rd and wr together.
   always_comb begin
      sel_addr  = cpu_addr_i;
      sel_wdata = cpu_wdata_i;
      sel_byte  = cpu_byte_op_i;
      sel_wr    = cpu_wr_i;
      if (grant_id == OWN_DMA) begin
         sel_addr  = dma_addr_i;
         sel_wdata = dma_wdata_i;
         sel_byte  = dma_byte_op_i;
         sel_wr    = dma_wr_i;
      end
   end

   assign cnt_d = cnt_q - CNT_W'(1);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         last_grant_q <= OWN_CPU;
         owner_q      <= OWN_CPU;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         byte_q       <= 1'b0;
         wr_q         <= 1'b0;
         ram_rd_q     <= 1'b0;
         ram_wr_q     <= 1'b0;
         cpu_ack_q    <= 1'b0;
         dma_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         dma_owner_q  <= 1'b0;
      end else begin
         cpu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_valid) begin
                  owner_q     <= grant_id;
                  dma_owner_q <= (grant_id == OWN_DMA);
                  addr_q      <= sel_addr;
                  wdata_q     <= sel_wdata;
                  byte_q      <= sel_byte;
                  wr_q        <= sel_wr;
                  cnt_q       <= CNT_LOAD;
                  ram_rd_q    <= ~sel_wr;
                  ram_wr_q    <= sel_wr;
                  state_q     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (cnt_q == '0) begin
                  if (!wr_q) begin
                     if (owner_q == OWN_DMA) dma_rdata_q <= ram_data_in_i;
                     else                    cpu_rdata_q <= ram_data_in_i;
                  end
                  ram_rd_q  <= 1'b0;
                  ram_wr_q  <= 1'b0;
                  cpu_ack_q <= (owner_q == OWN_CPU);
                  dma_ack_q <= (owner_q == OWN_DMA);
                  state_q   <= ST_DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_DONE: begin
               last_grant_q <= owner_q;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ram_addr_o     = addr_q;
   assign ram_data_out_o = wdata_q;
   assign ram_byte_op_o  = byte_q;
   assign ram_rd_o       = ram_rd_q;
   assign ram_wr_o       = ram_wr_q;
   assign cpu_ack_o      = cpu_ack_q;
   assign dma_ack_o      = dma_ack_q;
   assign cpu_rdata_o    = cpu_rdata_q;
   assign dma_rdata_o    = dma_rdata_q;
   assign dma_owner_o    = dma_owner_q;

endmodule

`default_nettype wire
